pm_bank_lanes_norm: RTL and testbench

//   Ping-pong path-metric store for the Viterbi ACS array, successor to the single-lane bank.

---
 rtl/pm_bank_lanes_norm.sv | 183 ++++++++++++++++++
 tb/tb_pm_bank_lanes_norm.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pm_bank_lanes_norm.sv
// Ping-pong path-metric store for a P-lane Viterbi ACS array.
// Tracks stage min/argmin and applies it as a read offset on the next stage.
module pm_bank_lanes_norm #(
  parameter int K       = 5,
  parameter int WM      = 8,
  parameter int P       = 2,
  parameter int NORM_EN = 1,
  localparam int M      = K - 1,
  localparam int S      = 1 << M
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init_frame,
  input  logic [M-1:0]    init_state,
  output logic            busy,
  input  logic [P*M-1:0]  rd_idx0,
  input  logic [P*M-1:0]  rd_idx1,
  output logic [P*WM-1:0] rd_pm0,
  output logic [P*WM-1:0] rd_pm1,
  input  logic [P-1:0]    wr_en,
  input  logic [P*M-1:0]  wr_idx,
  input  logic [P*WM-1:0] wr_pm,
  input  logic            swap_banks,
  output logic            prev_sel,
  output logic [M-1:0]    best_state,
  output logic [WM-1:0]   best_pm,
  output logic            best_valid,
  output logic            stage_err
);

  localparam int NC  = S / P;
  localparam int CIW = (NC > 1) ? $clog2(NC) : 1;
  localparam int CW  = $clog2(S * P + 1);
  localparam logic [WM-1:0] INF = '1;

  typedef enum logic {IDLE, INIT} state_t;

  state_t          state;
  logic [CIW-1:0]  icnt;
  logic [M-1:0]    init_lat;
  logic [WM-1:0]   norm_off;
  logic [CW-1:0]   wr_cnt;
  logic [WM-1:0]   run_min;
  logic [M-1:0]    run_arg;

  logic [WM-1:0]   bank [2][S];

  logic            act;
  logic            do_swap;
  logic [P-1:0]    we;
  logic [M-1:0]    init_idx [P];

  logic [WM-1:0]   c_min;
  logic [M-1:0]    c_arg;
  logic            c_any;
  logic [WM-1:0]   n_min;
  logic [M-1:0]    n_arg;
  logic [CW-1:0]   pop;
  logic [CW:0]     cnt_sum;
  logic [CW-1:0]   n_cnt;

  assign act     = (state == IDLE) && !init_frame;
  assign do_swap = swap_banks && act;
  assign we      = wr_en & {P{act}};

  // Stored all-ones stays all-ones so unreachable states never look reachable
  always_comb begin : rd_path
    logic [WM-1:0] a;
    logic [WM-1:0] b;
    rd_pm0 = '0;
    rd_pm1 = '0;
    for (int p = 0; p < P; p++) begin
      a = bank[prev_sel][rd_idx0[p*M +: M]];
      b = bank[prev_sel][rd_idx1[p*M +: M]];
      rd_pm0[p*WM +: WM] = (a == INF) ? INF : a - norm_off;
      rd_pm1[p*WM +: WM] = (b == INF) ? INF : b - norm_off;
    end
  end

  always_comb begin
    for (int p = 0; p < P; p++)
      init_idx[p] = M'(int'(icnt) * P + p);
  end

  always_comb begin : min_path
    logic [WM-1:0] v;
    logic [M-1:0]  i;
    c_min = INF;
    c_arg = '0;
    c_any = 1'b0;
    for (int p = 0; p < P; p++) begin
      v = wr_pm[p*WM +: WM];
      i = wr_idx[p*M +: M];
      if (we[p] && (!c_any || v < c_min ||
          (v == c_min && i < c_arg))) begin
        c_min = v;
        c_arg = i;
        c_any = 1'b1;
      end
    end
    n_min = run_min;
    n_arg = run_arg;
    if (c_any && (c_min < run_min ||
        (c_min == run_min && c_arg < run_arg))) begin
      n_min = c_min;
      n_arg = c_arg;
    end
    pop     = CW'($countones(we));
    cnt_sum = {1'b0, wr_cnt} + {1'b0, pop};
    n_cnt   = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (state == INIT && !init_frame) begin
      for (int p = 0; p < P; p++)
        bank[prev_sel][init_idx[p]] <=
          (init_idx[p] == init_lat) ? '0 : INF;
    end
    for (int p = 0; p < P; p++) begin
      if (we[p])
        bank[~prev_sel][wr_idx[p*M +: M]] <= wr_pm[p*WM +: WM];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      busy       <= 1'b1;
      icnt       <= '0;
      init_lat   <= '0;
      prev_sel   <= 1'b0;
      norm_off   <= '0;
      wr_cnt     <= '0;
      run_min    <= INF;
      run_arg    <= '0;
      best_state <= '0;
      best_pm    <= '0;
      best_valid <= 1'b0;
      stage_err  <= 1'b0;
    end else if (init_frame) begin
      state      <= INIT;
      busy       <= 1'b1;
      icnt       <= '0;
      init_lat   <= init_state;
      norm_off   <= '0;
      wr_cnt     <= '0;
      run_min    <= INF;
      run_arg    <= '0;
      best_valid <= 1'b0;
      stage_err  <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          if (icnt == CIW'(NC - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        IDLE: begin
          if (do_swap) begin
            prev_sel   <= ~prev_sel;
            best_pm    <= n_min;
            best_state <= n_arg;
            best_valid <= 1'b1;
            norm_off   <= (NORM_EN != 0) ? n_min : '0;
            stage_err  <= stage_err | (n_cnt != CW'(S));
            wr_cnt     <= '0;
            run_min    <= INF;
            run_arg    <= '0;
          end else begin
            wr_cnt  <= n_cnt;
            run_min <= n_min;
            run_arg <= n_arg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pm_bank_lanes_norm.sv
// Randomized bench for pm_bank_lanes_norm against a bank/stage model.
// K=5 (S=16), P=2, WM=8, NORM_EN=1.
module tb_pm_bank_lanes_norm;

  localparam int K  = 5;
  localparam int M  = 4;
  localparam int S  = 16;
  localparam int P  = 2;
  localparam int WM = 8;

  logic            clk;
  logic            rst;
  logic            init_frame;
  logic [M-1:0]    init_state;
  logic            busy;
  logic [P*M-1:0]  rd_idx0;
  logic [P*M-1:0]  rd_idx1;
  logic [P*WM-1:0] rd_pm0;
  logic [P*WM-1:0] rd_pm1;
  logic [P-1:0]    wr_en;
  logic [P*M-1:0]  wr_idx;
  logic [P*WM-1:0] wr_pm;
  logic            swap_banks;
  logic            prev_sel;
  logic [M-1:0]    best_state;
  logic [WM-1:0]   best_pm;
  logic            best_valid;
  logic            stage_err;

  pm_bank_lanes_norm #(.K(K), .WM(WM), .P(P), .NORM_EN(1)) dut (
    .clk(clk), .rst(rst),
    .init_frame(init_frame), .init_state(init_state),
    .busy(busy),
    .rd_idx0(rd_idx0), .rd_idx1(rd_idx1),
    .rd_pm0(rd_pm0), .rd_pm1(rd_pm1),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_pm(wr_pm),
    .swap_banks(swap_banks), .prev_sel(prev_sel),
    .best_state(best_state), .best_pm(best_pm),
    .best_valid(best_valid), .stage_err(stage_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  logic [7:0] mbank [2][16];
  bit         mps;
  logic [7:0] moff;
  bit         merr;
  bit         mvalid;
  logic [3:0] mbs;
  logic [7:0] mbp;

  int total = 0;
  int bad = 0;

  function automatic logic [7:0] mnorm(input logic [7:0] v);
    return (v == 8'hff) ? 8'hff : 8'(v - moff);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    init_frame = 0;
    wr_en      = '0;
    wr_idx     = '0;
    wr_pm      = '0;
    swap_banks = 0;
  endtask

  task automatic model_init(input logic [3:0] st);
    for (int i = 0; i < 16; i++)
      mbank[mps][i] = (i == int'(st)) ? 8'd0 : 8'hff;
    moff   = 0;
    merr   = 0;
    mvalid = 0;
  endtask

  task automatic check_reads(input string tag);
    logic [3:0] a0, a1, b0, b1;
    for (int i = 0; i < 16; i++) begin
      a0 = 4'(i);
      a1 = 4'(15 - i);
      b0 = 4'($urandom_range(0, 15));
      b1 = 4'($urandom_range(0, 15));
      rd_idx0 = {a1, a0};
      rd_idx1 = {b1, b0};
      #1;
      total += 4;
      if (rd_pm0[7:0] !== mnorm(mbank[mps][a0])) begin
        bad++;
        $display("FAIL %s rd0 lane0 idx%0d: got %0d exp %0d",
                 tag, a0, rd_pm0[7:0], mnorm(mbank[mps][a0]));
      end
      if (rd_pm0[15:8] !== mnorm(mbank[mps][a1])) begin
        bad++;
        $display("FAIL %s rd0 lane1 idx%0d: got %0d exp %0d",
                 tag, a1, rd_pm0[15:8], mnorm(mbank[mps][a1]));
      end
      if (rd_pm1[7:0] !== mnorm(mbank[mps][b0])) begin
        bad++;
        $display("FAIL %s rd1 lane0 idx%0d: got %0d exp %0d",
                 tag, b0, rd_pm1[7:0], mnorm(mbank[mps][b0]));
      end
      if (rd_pm1[15:8] !== mnorm(mbank[mps][b1])) begin
        bad++;
        $display("FAIL %s rd1 lane1 idx%0d: got %0d exp %0d",
                 tag, b1, rd_pm1[15:8], mnorm(mbank[mps][b1]));
      end
    end
  endtask

  task automatic check_status(input string tag);
    total += 3;
    if (prev_sel !== mps) begin
      bad++;
      $display("FAIL %s prev_sel: got %0b exp %0b", tag, prev_sel, mps);
    end
    if (best_valid !== mvalid) begin
      bad++;
      $display("FAIL %s best_valid: got %0b exp %0b", tag, best_valid, mvalid);
    end
    if (stage_err !== merr) begin
      bad++;
      $display("FAIL %s stage_err: got %0b exp %0b", tag, stage_err, merr);
    end
    if (mvalid) begin
      total += 2;
      if (best_state !== mbs) begin
        bad++;
        $display("FAIL %s best_state: got %0d exp %0d", tag, best_state, mbs);
      end
      if (best_pm !== mbp) begin
        bad++;
        $display("FAIL %s best_pm: got %0d exp %0d", tag, best_pm, mbp);
      end
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d exp 8", tag, n);
    end
  endtask

  task automatic start_init(input logic [3:0] st);
    init_state = st;
    init_frame = 1;
    step();
    init_frame = 0;
    model_init(st);
  endtask

  // mode 0 random, 1 ramp 20+s, 2 tie pattern
  task automatic run_stage(input string tag, input int mode,
                           input int nwr);
    logic [7:0] vals [16];
    int         perm [16];
    int         k, nl, t, j, ln;
    logic [7:0] emin;
    logic [3:0] earg;
    logic [3:0] ix;
    for (int i = 0; i < 16; i++) begin
      perm[i] = i;
      if (mode == 1)
        vals[i] = 8'(20 + i);
      else if (mode == 2)
        vals[i] = 8'($urandom_range(11, 254));
      else
        vals[i] = ($urandom_range(0, 7) == 0) ?
                  8'hff : 8'($urandom_range(0, 254));
    end
    if (mode == 2) begin
      vals[7] = 10;
      vals[2] = 10;
      vals[9] = 8'hff;
    end
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    emin = 8'hff;
    earg = 0;
    k = 0;
    while (k < nwr) begin
      nl = (nwr - k >= 2 && $urandom_range(0, 2) != 0) ? 2 : 1;
      wr_en = '0;
      for (int l = 0; l < nl; l++) begin
        ln = (nl == 2) ? l : $urandom_range(0, 1);
        ix = 4'(perm[k + l]);
        wr_en[ln] = 1;
        wr_idx[ln*M +: M] = ix;
        wr_pm[ln*WM +: WM] = vals[ix];
        mbank[!mps][ix] = vals[ix];
        if (vals[ix] < emin || (vals[ix] == emin && ix < earg)) begin
          emin = vals[ix];
          earg = ix;
        end
      end
      k += nl;
      swap_banks = (k == nwr);
      step();
      clear_in();
    end
    mbp    = emin;
    mbs    = earg;
    mvalid = 1;
    moff   = emin;
    merr   = merr | (nwr != 16);
    mps    = !mps;
    check_status(tag);
    check_reads(tag);
  endtask

  task automatic test_reset();
    mps = 0;
    model_init(0);
    wait_init("reset");
    check_status("reset");
    total += 2;
    if (best_pm !== 0 || best_state !== 0) begin
      bad++;
      $display("FAIL reset best: got %0d/%0d exp 0/0", best_pm, best_state);
    end
    if (prev_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset prev_sel0: got %0b exp 0", prev_sel);
    end
    check_reads("reset");
  endtask

  task automatic test_init();
    start_init(5);
    wait_init("init5");
    check_status("init5");
    rd_idx0 = {4'd4, 4'd5};
    #1;
    total += 2;
    if (rd_pm0[7:0] !== 8'd0) begin
      bad++;
      $display("FAIL init5 idx5: got %0d exp 0", rd_pm0[7:0]);
    end
    if (rd_pm0[15:8] !== 8'd255) begin
      bad++;
      $display("FAIL init5 idx4: got %0d exp 255", rd_pm0[15:8]);
    end
    check_reads("init5");
  endtask

  task automatic test_stage();
    run_stage("ramp", 1, 16);
    rd_idx0 = {4'd15, 4'd3};
    #1;
    total += 3;
    if (best_pm !== 8'd20 || best_state !== 4'd0) begin
      bad++;
      $display("FAIL ramp best: got %0d@%0d exp 20@0", best_pm, best_state);
    end
    if (rd_pm0[7:0] !== 8'd3) begin
      bad++;
      $display("FAIL ramp idx3: got %0d exp 3", rd_pm0[7:0]);
    end
    if (rd_pm0[15:8] !== 8'd15) begin
      bad++;
      $display("FAIL ramp idx15: got %0d exp 15", rd_pm0[15:8]);
    end
  endtask

  task automatic test_ties();
    run_stage("tie", 2, 16);
    rd_idx0 = {4'd9, 4'd2};
    #1;
    total += 2;
    if (best_state !== 4'd2) begin
      bad++;
      $display("FAIL tie argmin: got %0d exp 2", best_state);
    end
    if (rd_pm0[15:8] !== 8'd255) begin
      bad++;
      $display("FAIL tie inf idx9: got %0d exp 255", rd_pm0[15:8]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_stage("rand", 0, 16);
  endtask

  task automatic test_stage_err();
    run_stage("err14", 0, 14);
    run_stage("err_hold", 0, 16);
    run_stage("err_hold2", 0, 16);
    start_init(4'($urandom_range(0, 15)));
    wait_init("err_clr");
    check_status("err_clr");
    check_reads("err_clr");
  endtask

  task automatic test_init_mid();
    start_init(3);
    repeat (3) step();
    init_state = 9;
    init_frame = 1;
    wr_en      = 2'b11;
    swap_banks = 1;
    step();
    init_frame = 0;
    model_init(9);
    begin
      int n = 0;
      while (busy === 1'b1 && n < 40) begin
        wr_en      = 2'($urandom);
        wr_idx     = 8'($urandom);
        wr_pm      = 16'($urandom);
        swap_banks = 1'($urandom);
        step();
        n++;
      end
      clear_in();
      total++;
      if (n != 8) begin
        bad++;
        $display("FAIL mid_init busy cycles: got %0d exp 8", n);
      end
    end
    check_status("mid_init");
    check_reads("mid_init");
    run_stage("post_mid", 0, 16);
  endtask

  initial begin
    clear_in();
    init_state = 0;
    rd_idx0 = '0;
    rd_idx1 = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_init();
    test_stage();
    test_ties();
    test_random();
    test_stage_err();
    test_init_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
